// File: rtl/usb_rx.sv
// usb_rx: USB full-speed receiver.
// The block synchronizes D+/D-, recovers bit timing from D+ edges and samples once per bit.
// It NRZI-decodes and unstuffs the bits, then assembles bytes LSB-first.
// It validates SYNC and PID, checks the body length and detects EOP.
// Ports:
//   clk, rst                  clock, async active-high reset
//   dplus_in, dminus_in       raw USB lines
//   buffer_occupancy          packet FIFO fill count (FIFO_DEPTH == full)
//   rx_packet                 0 none,1 IN,2 OUT,3 DATA0,4 DATA1,5 ACK,6 NAK,7 STALL
//   rx_data_ready             1-cycle pulse on error-free packet completion
//   rx_transfer_active        high from SYNC start until back in IDLE
//   rx_error                  sticky until the next SYNC start
//   flush                     1-cycle pulse after a DATA PID
//   store_rx_packet_data      FIFO write strobe, rx_packet_data is the byte
module usb_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic [6:0] buffer_occupancy,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       flush,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_SAMP = TW'(SAMPLE_PHASE);
  localparam logic [6:0]    FULL   = 7'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_PID  = 3'd2;
  localparam logic [2:0] ST_BODY = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic          dp_s1, dp_s2, dm_s1, dm_s2, dp_q;
  logic [TW-1:0] timer;
  logic          prev;
  logic [2:0]    ones;
  logic [3:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [1:0]    se0_cnt;
  logic [2:0]    state, code, body_cnt;

  // line decode at the sample point
  logic sample, line_se0, line_j, line_k;
  logic eop, frame_err, data_smp, nrzi_bit, stuff_bit, stuff_err, bit_ok, byte_done, start;
  logic [7:0] byte_val;
  logic [2:0] pid_code;
  logic is_tok, is_hs, is_data, len_ok, body_byte_ok, fail;

  assign sample   = (timer == T_SAMP);
  assign line_se0 = ~dp_s2 & ~dm_s2;
  assign line_j   =  dp_s2 & ~dm_s2;
  assign line_k   = ~dp_s2 &  dm_s2;

  // EOP = SE0, SE0, J. Any non-SE0 after a lone SE0, or K after two, is a framing error.
  assign eop       = sample & line_j & (se0_cnt == 2'd2);
  assign frame_err = sample & ~line_se0 &
                     ((se0_cnt == 2'd1) | ((se0_cnt == 2'd2) & ~line_j));
  assign data_smp  = sample & ~line_se0 & (se0_cnt == 2'd0);
  assign nrzi_bit  = (dp_s2 == prev);
  assign stuff_bit = data_smp & (ones == 3'd6);
  assign stuff_err = stuff_bit & nrzi_bit;
  assign bit_ok    = data_smp & ~stuff_bit;
  assign byte_done = bit_ok & (bit_cnt == 4'd7);
  assign byte_val  = {nrzi_bit, shreg};
  // prev==1 means the last sample was J, so a K now is the first SYNC edge
  assign start     = (state == ST_IDLE) & sample & line_k & prev;

  always_comb begin
    pid_code = 3'd0;
    if (byte_val[7:4] == ~byte_val[3:0]) begin
      case (byte_val[3:0])
        4'b1001: pid_code = 3'd1;
        4'b0001: pid_code = 3'd2;
        4'b0011: pid_code = 3'd3;
        4'b1011: pid_code = 3'd4;
        4'b0010: pid_code = 3'd5;
        4'b1010: pid_code = 3'd6;
        4'b1110: pid_code = 3'd7;
        default: pid_code = 3'd0;
      endcase
    end
  end

  assign is_tok  = (code == 3'd1) | (code == 3'd2);
  assign is_data = (code == 3'd3) | (code == 3'd4);
  assign is_hs   = (code >= 3'd5);
  // data packets must at least carry their CRC16
  assign len_ok  = (bit_cnt == 4'd0) &
                   ((is_tok & (body_cnt == 3'd2)) | (is_hs & (body_cnt == 3'd0)) |
                    (is_data & (body_cnt >= 3'd2)));
  assign body_byte_ok = is_data ? (buffer_occupancy != FULL) : (is_tok & (body_cnt < 3'd2));

  always_comb begin
    fail = 1'b0;
    case (state)
      ST_SYNC: fail = stuff_err | frame_err | eop | (sample & line_se0) |
                      (byte_done & (byte_val != 8'h80));
      ST_PID:  fail = stuff_err | frame_err | eop | (byte_done & (pid_code == 3'd0));
      ST_BODY: fail = stuff_err | frame_err | (eop & ~len_ok) | (byte_done & ~body_byte_ok);
      default: fail = 1'b0;
    endcase
  end

  // synchronizers, bit timing, NRZI, unstuffing, byte assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1 <= 1'b1; dp_s2 <= 1'b1; dp_q <= 1'b1;
      dm_s1 <= 1'b0; dm_s2 <= 1'b0;
      timer <= '0; prev <= 1'b1; ones <= 3'd0;
      bit_cnt <= 4'd0; shreg <= 7'd0; se0_cnt <= 2'd0;
    end else begin
      dp_s1 <= dplus_in;  dp_s2 <= dp_s1; dp_q <= dp_s2;
      dm_s1 <= dminus_in; dm_s2 <= dm_s1;
      if (dp_s2 != dp_q)      timer <= '0;
      else if (timer == T_LAST) timer <= '0;
      else                    timer <= timer + 1'b1;
      if (sample) begin
        prev    <= dp_s2;
        se0_cnt <= line_se0 ? ((se0_cnt == 2'd2) ? 2'd2 : se0_cnt + 2'd1) : 2'd0;
      end
      if (start) begin
        // first SYNC bit (a 0) is already in the bag
        bit_cnt <= 4'd1; ones <= 3'd0; shreg <= 7'd0;
      end else if (bit_ok) begin
        shreg   <= byte_val[7:1];
        bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
        ones    <= nrzi_bit ? ones + 3'd1 : 3'd0;
      end else if (stuff_bit) begin
        ones <= 3'd0;
      end
    end
  end

  // packet FSM and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE; code <= 3'd0; body_cnt <= 3'd0;
      rx_packet <= 3'd0; rx_data_ready <= 1'b0; rx_transfer_active <= 1'b0;
      rx_error <= 1'b0; flush <= 1'b0; store_rx_packet_data <= 1'b0; rx_packet_data <= 8'd0;
    end else begin
      flush <= 1'b0; store_rx_packet_data <= 1'b0; rx_data_ready <= 1'b0;
      if (fail) begin
        state <= ST_ERR; rx_error <= 1'b1; rx_packet <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state <= ST_SYNC; rx_transfer_active <= 1'b1; rx_error <= 1'b0; rx_packet <= 3'd0;
          end
          ST_SYNC: if (byte_done) state <= ST_PID;
          ST_PID: if (byte_done) begin
            code <= pid_code; body_cnt <= 3'd0; state <= ST_BODY;
            flush <= (pid_code == 3'd3) | (pid_code == 3'd4);
          end
          ST_BODY: begin
            if (eop) begin
              rx_packet <= code; rx_data_ready <= 1'b1;
              rx_transfer_active <= 1'b0; state <= ST_IDLE;
            end else if (byte_done) begin
              if (body_cnt != 3'd7) body_cnt <= body_cnt + 3'd1;
              if (is_data) begin
                store_rx_packet_data <= 1'b1; rx_packet_data <= byte_val;
              end
            end
          end
          ST_ERR: if (eop) begin
            state <= ST_IDLE; rx_transfer_active <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: builds USB packets as bit lists and stuffs them. It NRZI-drives them onto D+/D-.
// It then compares the receiver outputs against expectations derived from the packet contents.
module tb_usb_rx;
  localparam int CPB = 8;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic       clk = 1'b0, rst, dp, dm;
  logic [6:0] occ;
  logic [2:0] rx_packet;
  logic       rx_data_ready, rx_transfer_active, rx_error, flush, store;
  logic [7:0] rx_packet_data;

  always #5 clk = ~clk;

  usb_rx #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(3), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .dplus_in(dp), .dminus_in(dm), .buffer_occupancy(occ),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
    .rx_transfer_active(rx_transfer_active), .rx_error(rx_error), .flush(flush),
    .store_rx_packet_data(store), .rx_packet_data(rx_packet_data));

  int n_chk = 0, n_pass = 0;

  // pulse monitor, sampled on the falling edge
  int mon_store = 0, mon_flush = 0, mon_ready = 0;
  logic [7:0] mon_bytes[$];
  always @(negedge clk) begin
    if (store) begin mon_store++; mon_bytes.push_back(rx_packet_data); end
    if (flush) mon_flush++;
    if (rx_data_ready) mon_ready++;
  end

  // reference: PID byte table, index+1 is the packet code
  logic [7:0] pid_tab[7] = '{8'h69, 8'hE1, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};

  bit bitq[$];
  int ones;

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      bitq.push_back(b[i]);
      if (b[i]) ones++; else ones = 0;
      if (ones == 6) begin bitq.push_back(1'b0); ones = 0; end
    end
  endtask

  task automatic start_pkt(input logic [7:0] pid);
    bitq.delete(); ones = 0;
    add_byte(8'h80);
    add_byte(pid);
  endtask

  task automatic drive_sym(input logic [1:0] s);
    {dp, dm} = s;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input int limit, input bit with_eop, input int idle);
    logic [1:0] lvl = J;
    int n = (limit < 0 || limit > bitq.size()) ? bitq.size() : limit;
    for (int i = 0; i < n; i++) begin
      if (!bitq[i]) lvl = ~lvl;
      drive_sym(lvl);
    end
    if (with_eop) begin
      drive_sym(SE0); drive_sym(SE0); drive_sym(J);
      repeat (idle) drive_sym(J);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dp = 1'b1; dm = 1'b0; occ = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({rx_packet, rx_data_ready, rx_transfer_active, rx_error, flush, store, rx_packet_data} !== 16'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {rx_packet, rx_data_ready, rx_transfer_active, rx_error, flush, store, rx_packet_data});
    else n_pass++;
    rst = 1'b0;
    repeat (3) drive_sym(J);
  endtask

  task automatic test_ack();
    int r0 = mon_ready, s0 = mon_store;
    start_pkt(8'hD2); send(-1, 1, 2);
    n_chk++; if (rx_packet !== 3'd5) $display("FAIL ack_pkt: got %0d required 5", rx_packet); else n_pass++;
    n_chk++; if (mon_ready - r0 !== 1) $display("FAIL ack_ready: got %0d required 1", mon_ready - r0); else n_pass++;
    n_chk++; if (mon_store - s0 !== 0) $display("FAIL ack_store: got %0d required 0", mon_store - s0); else n_pass++;
    n_chk++; if (rx_error !== 1'b0 || rx_transfer_active !== 1'b0)
      $display("FAIL ack_flags: got err=%b act=%b required 0 0", rx_error, rx_transfer_active); else n_pass++;
  endtask

  task automatic test_data0();
    logic [7:0] pl[5];
    int r0 = mon_ready, s0 = mon_store, f0 = mon_flush, b0 = mon_bytes.size();
    pl[0] = 8'h01; pl[1] = 8'hFF; pl[2] = 8'h3C;
    pl[3] = 8'($urandom); pl[4] = 8'($urandom);
    occ = 7'($urandom_range(0, 59));
    start_pkt(8'hC3);
    for (int i = 0; i < 5; i++) add_byte(pl[i]);
    send(-1, 1, 2);
    n_chk++; if (mon_flush - f0 !== 1) $display("FAIL data0_flush: got %0d required 1", mon_flush - f0); else n_pass++;
    n_chk++; if (mon_store - s0 !== 5) $display("FAIL data0_store: got %0d required 5", mon_store - s0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (b0 + i >= mon_bytes.size() || mon_bytes[b0 + i] !== pl[i])
        $display("FAIL data0_byte%0d: got %h required %h", i,
                 (b0 + i < mon_bytes.size()) ? mon_bytes[b0 + i] : 8'hxx, pl[i]);
      else n_pass++;
    end
    n_chk++; if (rx_packet !== 3'd3) $display("FAIL data0_pkt: got %0d required 3", rx_packet); else n_pass++;
    n_chk++; if (mon_ready - r0 !== 1) $display("FAIL data0_ready: got %0d required 1", mon_ready - r0); else n_pass++;
  endtask

  task automatic test_bad_pid();
    int r0 = mon_ready, s0 = mon_store;
    start_pkt(8'h2A); send(-1, 1, 2);
    n_chk++; if (rx_error !== 1'b1) $display("FAIL badpid_err: got %b required 1", rx_error); else n_pass++;
    n_chk++; if (rx_packet !== 3'd0) $display("FAIL badpid_pkt: got %0d required 0", rx_packet); else n_pass++;
    n_chk++; if (rx_transfer_active !== 1'b0) $display("FAIL badpid_act: got %b required 0", rx_transfer_active); else n_pass++;
    n_chk++; if (mon_store - s0 !== 0 || mon_ready - r0 !== 0)
      $display("FAIL badpid_pulses: got store=%0d ready=%0d required 0 0", mon_store - s0, mon_ready - r0); else n_pass++;
  endtask

  task automatic test_stuff_err();
    logic [7:0] d = 8'($urandom);
    int r0 = mon_ready, s0 = mon_store, b0 = mon_bytes.size();
    start_pkt(8'h4B); add_byte(d);
    repeat (7) bitq.push_back(1'b1);   // unstuffed run of seven 1s
    ones = 0; add_byte(8'h00); add_byte(8'h5A);
    send(-1, 1, 2);
    n_chk++; if (rx_error !== 1'b1) $display("FAIL stuff_err: got %b required 1", rx_error); else n_pass++;
    n_chk++; if (mon_store - s0 !== 1) $display("FAIL stuff_store: got %0d required 1", mon_store - s0); else n_pass++;
    n_chk++; if (b0 >= mon_bytes.size() || mon_bytes[b0] !== d)
      $display("FAIL stuff_byte: got %h required %h", (b0 < mon_bytes.size()) ? mon_bytes[b0] : 8'hxx, d); else n_pass++;
    n_chk++; if (mon_ready - r0 !== 0 || rx_packet !== 3'd0)
      $display("FAIL stuff_ready: got ready=%0d pkt=%0d required 0 0", mon_ready - r0, rx_packet); else n_pass++;
  endtask

  task automatic test_overflow();
    int r0 = mon_ready, s0 = mon_store, f0 = mon_flush;
    occ = 7'd64;
    start_pkt(8'hC3);
    for (int i = 0; i < 3; i++) add_byte(8'($urandom));
    send(-1, 1, 2);
    occ = 7'd0;
    n_chk++; if (mon_store - s0 !== 0) $display("FAIL ovf_store: got %0d required 0", mon_store - s0); else n_pass++;
    n_chk++; if (rx_error !== 1'b1) $display("FAIL ovf_err: got %b required 1", rx_error); else n_pass++;
    n_chk++; if (mon_flush - f0 !== 1 || mon_ready - r0 !== 0)
      $display("FAIL ovf_pulses: got flush=%0d ready=%0d required 1 0", mon_flush - f0, mon_ready - r0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int r0, s0;
    start_pkt(8'hC3);
    for (int i = 0; i < 4; i++) add_byte(8'($urandom));
    send(30, 0, 0);
    n_chk++; if (rx_transfer_active !== 1'b1) $display("FAIL rstmid_active: got %b required 1", rx_transfer_active); else n_pass++;
    rst = 1'b1; #1;
    n_chk++;
    if ({rx_packet, rx_data_ready, rx_transfer_active, rx_error, flush, store, rx_packet_data} !== 16'd0)
      $display("FAIL rstmid_outputs: got %h required 0",
               {rx_packet, rx_data_ready, rx_transfer_active, rx_error, flush, store, rx_packet_data});
    else n_pass++;
    {dp, dm} = J;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (3) drive_sym(J);
    r0 = mon_ready; s0 = mon_store;
    start_pkt(8'hE1); add_byte(8'($urandom)); add_byte(8'($urandom));
    send(-1, 1, 2);
    n_chk++; if (rx_packet !== 3'd2) $display("FAIL rstmid_pkt: got %0d required 2", rx_packet); else n_pass++;
    n_chk++; if (mon_ready - r0 !== 1 || mon_store - s0 !== 0 || rx_error !== 1'b0)
      $display("FAIL rstmid_out: got ready=%0d store=%0d err=%b required 1 0 0",
               mon_ready - r0, mon_store - s0, rx_error); else n_pass++;
  endtask

  // random valid packets, some sent back-to-back with no idle gap
  task automatic test_random(input int n_pkts, input int idle);
    for (int p = 0; p < n_pkts; p++) begin
      int idx = $urandom_range(0, 6);
      int nb = (idx < 2) ? 2 : (idx < 4) ? $urandom_range(2, 6) : 0;
      bit data = (idx == 2 || idx == 3);
      logic [7:0] pl[$];
      int r0 = mon_ready, s0 = mon_store, f0 = mon_flush, b0 = mon_bytes.size();
      occ = 7'($urandom_range(0, 50));
      start_pkt(pid_tab[idx]);
      for (int i = 0; i < nb; i++) begin pl.push_back(8'($urandom)); add_byte(pl[i]); end
      send(-1, 1, idle);
      n_chk++; if (rx_packet !== 3'(idx + 1))
        $display("FAIL rand%0d_pkt: got %0d required %0d", p, rx_packet, idx + 1); else n_pass++;
      n_chk++; if (mon_ready - r0 !== 1 || rx_error !== 1'b0)
        $display("FAIL rand%0d_ready: got ready=%0d err=%b required 1 0", p, mon_ready - r0, rx_error); else n_pass++;
      n_chk++; if (mon_store - s0 !== (data ? nb : 0) || mon_flush - f0 !== (data ? 1 : 0))
        $display("FAIL rand%0d_strobes: got store=%0d flush=%0d required %0d %0d", p,
                 mon_store - s0, mon_flush - f0, data ? nb : 0, data ? 1 : 0); else n_pass++;
      if (data) begin
        for (int i = 0; i < nb; i++) begin
          n_chk++;
          if (b0 + i >= mon_bytes.size() || mon_bytes[b0 + i] !== pl[i])
            $display("FAIL rand%0d_byte%0d: got %h required %h", p, i,
                     (b0 + i < mon_bytes.size()) ? mon_bytes[b0 + i] : 8'hxx, pl[i]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data0();
    test_bad_pid();
    test_ack();
    test_stuff_err();
    test_overflow();
    test_reset_mid();
    test_random(12, 2);
    test_random(6, 0);
    repeat (2) drive_sym(J);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
